// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Captures decoded operands and control, resolves operand hazards by EX/MEM and
// MEM/WB forwarding plus decode-time write-through, detects load-use hazards
// (stall request upstream, bubble into EX), and honours external stall/flush.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs_addr,
   input  logic [REG_W-1:0]  id_rt_addr,
   input  logic [REG_W-1:0]  id_rd_addr,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_control,
   input  logic              id_alusrc,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              stall,
   input  logic              flush,
   input  logic              exmem_regwrite,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] salida1,
   output logic [DATA_W-1:0] salida3,
   output logic [CTRL_W-1:0] ex_control,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_W-1:0]  ex_dest,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              load_use_stall
);

   // Registered EX-slot state
   logic              valid_q,    valid_d;
   logic [REG_W-1:0]  rs_q,       rs_d;
   logic [REG_W-1:0]  rt_q,       rt_d;
   logic [REG_W-1:0]  rd_q,       rd_d;
   logic [DATA_W-1:0] rs_data_q,  rs_data_d;
   logic [DATA_W-1:0] rt_data_q,  rt_data_d;
   logic [DATA_W-1:0] imm_q,      imm_d;
   logic [CTRL_W-1:0] control_q,  control_d;
   logic              alusrc_q,   alusrc_d;
   logic              regwrite_q, regwrite_d;
   logic              memread_q,  memread_d;
   logic              memwrite_q, memwrite_d;

   logic [DATA_W-1:0] wt_rs_data;
   logic [DATA_W-1:0] wt_rt_data;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic              load_bubble;

   // Load in EX whose result a dependent instruction in ID needs this cycle.
   // rt only matters when it is a real ALU operand or store data.
   always_comb begin
      load_use_stall = valid_q && memread_q && (rd_q != '0) && id_valid &&
                       ((rd_q == id_rs_addr) ||
                        ((rd_q == id_rt_addr) && (!id_alusrc || id_memwrite)));
   end

   // Decode write-through: a register being written back this cycle overrides the
   // stale register-file read.
   always_comb begin
      wt_rs_data = id_rs_data;
      wt_rt_data = id_rt_data;
      if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs_addr))
         wt_rs_data = memwb_result;
      if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rt_addr))
         wt_rt_data = memwb_result;
   end

   // Next-state selection: flush > stall > load-use bubble > capture.
   always_comb begin
      // NOTE: every _d takes its _q as a default before any branch, so no path leaves it unassigned and no latch is inferred.
      valid_d    = valid_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      control_d  = control_q;
      alusrc_d   = alusrc_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      load_bubble = flush || (!stall && load_use_stall);
      if (load_bubble) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         control_d  = '0;
      end else if (!stall) begin
         valid_d    = id_valid;
         rs_d       = id_rs_addr;
         rt_d       = id_rt_addr;
         rd_d       = id_rd_addr;
         rs_data_d  = wt_rs_data;
         rt_data_d  = wt_rt_data;
         imm_d      = id_imm;
         control_d  = id_control;
         alusrc_d   = id_alusrc;
         regwrite_d = id_valid && id_regwrite && (id_rd_addr != '0);
         memread_d  = id_valid && id_memread;
         memwrite_d = id_valid && id_memwrite;
      end
   end

   // EX-slot state register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         control_q  <= '0;
         alusrc_q   <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         valid_q    <= valid_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         control_q  <= control_d;
         alusrc_q   <= alusrc_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
      end
   end

   // Operand forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      fwd_rt = rt_data_q;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_q))
         fwd_rs = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_q))
         fwd_rs = memwb_result;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_q))
         fwd_rt = exmem_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_q))
         fwd_rt = memwb_result;
   end

   assign ex_valid      = valid_q;
   assign salida1       = fwd_rs;
   assign salida3       = alusrc_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_control    = control_q;
   assign ex_dest       = rd_q;
   assign ex_regwrite   = regwrite_q;
   assign ex_memread    = memread_q;
   assign ex_memwrite   = memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a vector table run through a scoreboard
// queue, followed by hand-written sequences for forwarding, load-use, priority,
// stall hold and reset corner cases.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]  id_control;
   logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
   logic        stall, flush;
   logic        exmem_regwrite;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_regwrite;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_result;
   logic        ex_valid;
   logic [31:0] salida1, salida3, ex_store_data;
   logic [3:0]  ex_control;
   logic [4:0]  ex_dest;
   logic        ex_regwrite, ex_memread, ex_memwrite;
   logic        load_use_stall;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        v;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_data, rt_data, imm;
      logic [3:0]  ctrl;
      logic        alusrc, rw, mr, mw;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_res;
      logic        e_valid;
      logic [31:0] e_s1, e_s3, e_store;
      logic [3:0]  e_ctrl;
      logic [4:0]  e_dest;
      logic        e_rw, e_mr, e_mw;
   } vec_t;

   typedef struct {
      logic        valid;
      logic [31:0] s1, s3, store;
      logic [3:0]  ctrl;
      logic [4:0]  dest;
      logic        rw, mr, mw;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[11];
   vec_t hv;

   id_ex_stage #(.DATA_W(32), .CTRL_W(4), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_control(id_control), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite),
      .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .salida1(salida1), .salida3(salida3), .ex_control(ex_control),
      .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_fwd();
      exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
      memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
   endtask

   task automatic idle_id();
      id_valid = 1'b0; id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_control = '0;
      id_alusrc = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " ex_valid"},       ex_valid,       0);
      check({tag, " ex_control"},     ex_control,     0);
      check({tag, " ex_dest"},        ex_dest,        0);
      check({tag, " ex_regwrite"},    ex_regwrite,    0);
      check({tag, " ex_memread"},     ex_memread,     0);
      check({tag, " ex_memwrite"},    ex_memwrite,    0);
      check({tag, " salida1"},        salida1,        0);
      check({tag, " salida3"},        salida3,        0);
      check({tag, " ex_store_data"},  ex_store_data,  0);
      check({tag, " load_use_stall"}, load_use_stall, 0);
   endtask

   // Drive one decode slot, push its expectation, clock it in, then compare with
   // forwarding sources quiet so only the captured values are visible.
   task automatic apply_vec(input vec_t v, input string tag);
      exp_t e;
      exp_t got;
      id_valid = v.v; id_rs_addr = v.rs; id_rt_addr = v.rt; id_rd_addr = v.rd;
      id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
      id_control = v.ctrl; id_alusrc = v.alusrc; id_regwrite = v.rw;
      id_memread = v.mr; id_memwrite = v.mw;
      memwb_regwrite = v.wb_rw; memwb_rd = v.wb_rd; memwb_result = v.wb_res;
      e = '{valid: v.e_valid, s1: v.e_s1, s3: v.e_s3, store: v.e_store, ctrl: v.e_ctrl,
            dest: v.e_dest, rw: v.e_rw, mr: v.e_mr, mw: v.e_mw};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      clear_fwd();
      #1;
      got = sb_q.pop_front();
      check({tag, " ex_valid"},      ex_valid,      got.valid);
      check({tag, " salida1"},       salida1,       got.s1);
      check({tag, " salida3"},       salida3,       got.s3);
      check({tag, " ex_store_data"}, ex_store_data, got.store);
      check({tag, " ex_control"},    ex_control,    got.ctrl);
      check({tag, " ex_dest"},       ex_dest,       got.dest);
      check({tag, " ex_regwrite"},   ex_regwrite,   got.rw);
      check({tag, " ex_memread"},    ex_memread,    got.mr);
      check({tag, " ex_memwrite"},   ex_memwrite,   got.mw);
   endtask

   initial begin
      // fields: v rs rt rd rs_data rt_data imm ctrl alusrc rw mr mw | wb_rw wb_rd wb_res |
      //         e_valid e_s1 e_s3 e_store e_ctrl e_dest e_rw e_mr e_mw
      vecs[0]  = '{1, 1, 2, 3, 5, 7, 0, 2, 0, 1, 0, 0,  0, 0, 0,  1, 5, 7, 7, 2, 3, 1, 0, 0};
      vecs[1]  = '{1, 1, 2, 4, 32'h20, 9, 32'h10, 3, 1, 1, 0, 0,  0, 0, 0,  1, 32'h20, 32'h10, 9, 3, 4, 1, 0, 0};
      vecs[2]  = '{0, 1, 2, 5, 1, 2, 0, 6, 0, 1, 1, 0,  0, 0, 0,  0, 1, 2, 2, 6, 5, 0, 0, 0};
      vecs[3]  = '{1, 3, 4, 0, 8, 9, 0, 1, 0, 1, 0, 0,  0, 0, 0,  1, 8, 9, 9, 1, 0, 0, 0, 0};
      vecs[4]  = '{1, 5, 6, 0, 32'h100, 32'hCAFE, 4, 0, 1, 0, 0, 1,  0, 0, 0,  1, 32'h100, 4, 32'hCAFE, 0, 0, 0, 0, 1};
      vecs[5]  = '{1, 5, 0, 9, 32'h200, 0, 8, 0, 1, 1, 1, 0,  0, 0, 0,  1, 32'h200, 8, 0, 0, 9, 1, 1, 0};
      vecs[6]  = '{1, 1, 9, 2, 1, 2, 32'h33, 2, 1, 1, 0, 0,  0, 0, 0,  1, 1, 32'h33, 2, 2, 2, 1, 0, 0};
      vecs[7]  = '{1, 4, 2, 3, 0, 7, 0, 2, 0, 1, 0, 0,  1, 4, 32'h1234,  1, 32'h1234, 7, 7, 2, 3, 1, 0, 0};
      vecs[8]  = '{1, 1, 6, 3, 5, 0, 0, 2, 0, 1, 0, 0,  1, 6, 32'h5678,  1, 5, 32'h5678, 32'h5678, 2, 3, 1, 0, 0};
      vecs[9]  = '{1, 0, 0, 3, 32'h11, 32'h22, 0, 2, 0, 1, 0, 0,  1, 0, 32'hDEAD,  1, 32'h11, 32'h22, 32'h22, 2, 3, 1, 0, 0};
      vecs[10] = '{1, 6, 6, 3, 32'h11, 32'h22, 0, 2, 0, 1, 0, 0,  0, 6, 32'hDEAD,  1, 32'h11, 32'h22, 32'h22, 2, 3, 1, 0, 0};

      // Power-on reset
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      idle_id();
      clear_fwd();
      #3;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 11; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
         if (i == 5) check("vec6 no load-use via imm rt", load_use_stall, 0);
      end

      // EX/MEM forwarding beats MEM/WB, MEM/WB used when EX/MEM drops out
      hv = '{1, 3, 5, 7, 32'h11, 32'h22, 0, 1, 0, 1, 0, 0,  0, 0, 0,  1, 32'h11, 32'h22, 32'h22, 1, 7, 1, 0, 0};
      apply_vec(hv, "fwd_base");
      idle_id();
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
      #1 check("fwd exmem rs", salida1, 32'hAA);
      memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
      #1 check("fwd exmem priority", salida1, 32'hAA);
      exmem_regwrite = 1'b0;
      #1 check("fwd memwb rs", salida1, 32'hBB);
      memwb_rd = 5'd5;
      #1;
      check("fwd none rs", salida1, 32'h11);
      check("fwd memwb store", ex_store_data, 32'hBB);
      check("fwd memwb salida3", salida3, 32'hBB);
      clear_fwd();

      // Register 0 is never forwarded
      hv = '{1, 0, 0, 7, 32'h77, 32'h66, 0, 1, 0, 1, 0, 0,  0, 0, 0,  1, 32'h77, 32'h66, 32'h66, 1, 7, 1, 0, 0};
      apply_vec(hv, "r0_base");
      exmem_regwrite = 1'b1; exmem_rd = '0; exmem_result = 32'hAA;
      memwb_regwrite = 1'b1; memwb_rd = '0; memwb_result = 32'hBB;
      #1;
      check("r0 guard salida1", salida1, 32'h77);
      check("r0 guard store", ex_store_data, 32'h66);
      clear_fwd();

      // Load-use on rs: stall request, bubble, then the dependent op enters
      hv = '{1, 1, 2, 8, 32'h40, 32'h50, 4, 0, 1, 1, 1, 0,  0, 0, 0,  1, 32'h40, 4, 32'h50, 0, 8, 1, 1, 0};
      apply_vec(hv, "load1");
      idle_id();
      id_valid = 1'b1; id_rs_addr = 5'd8; id_rt_addr = 5'd3; id_rd_addr = 5'd10;
      id_rs_data = 32'h80; id_control = 4'd7; id_regwrite = 1'b1;
      #1 check("lu rs stall", load_use_stall, 1);
      @(posedge clk); #1;
      check("lu bubble ex_valid", ex_valid, 0);
      check("lu bubble memread", ex_memread, 0);
      check("lu bubble regwrite", ex_regwrite, 0);
      check("lu bubble control", ex_control, 0);
      check("lu released", load_use_stall, 0);
      @(posedge clk); #1;
      check("lu dep ex_valid", ex_valid, 1);
      check("lu dep salida1", salida1, 32'h80);
      check("lu dep ex_dest", ex_dest, 10);

      // Load-use on rt only counts when rt is a real operand or store data
      hv = '{1, 1, 2, 8, 32'h40, 32'h50, 4, 0, 1, 1, 1, 0,  0, 0, 0,  1, 32'h40, 4, 32'h50, 0, 8, 1, 1, 0};
      apply_vec(hv, "load2");
      idle_id();
      id_valid = 1'b1; id_rs_addr = 5'd1; id_rt_addr = 5'd8; id_alusrc = 1'b1;
      #1 check("lu rt imm no stall", load_use_stall, 0);
      id_memwrite = 1'b1;
      #1 check("lu rt store stall", load_use_stall, 1);
      id_memwrite = 1'b0; id_alusrc = 1'b0; id_rs_addr = 5'd8; id_valid = 1'b0;
      #1 check("lu invalid id no stall", load_use_stall, 0);
      id_valid = 1'b1; flush = 1'b1;
      #1 check("lu with flush stall seen", load_use_stall, 1);
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush+lu bubble", ex_valid, 0);
      check("flush+lu memread", ex_memread, 0);

      // flush beats stall, and a held bubble stays a bubble
      hv = '{1, 1, 2, 11, 32'h99, 32'h98, 0, 5, 0, 1, 0, 0,  0, 0, 0,  1, 32'h99, 32'h98, 32'h98, 5, 11, 1, 0, 0};
      apply_vec(hv, "prio_base");
      idle_id();
      id_valid = 1'b1; id_control = 4'd9; id_rd_addr = 5'd13; id_regwrite = 1'b1;
      flush = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      check("flush+stall ex_valid", ex_valid, 0);
      check("flush+stall control", ex_control, 0);
      check("flush+stall regwrite", ex_regwrite, 0);
      flush = 1'b0;
      @(posedge clk); #1;
      check("stalled bubble ex_valid", ex_valid, 0);
      stall = 1'b0;

      // Stall holds for 3 cycles while ID changes underneath
      hv = '{1, 1, 2, 12, 32'h12345678, 32'hABCD, 0, 3, 0, 1, 0, 0,  0, 0, 0,  1, 32'h12345678, 32'hABCD, 32'hABCD, 3, 12, 1, 0, 0};
      apply_vec(hv, "hold_base");
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         id_valid = 1'b1;
         id_control = 4'(k + 8);
         id_rs_data = 32'hF0 + 32'(k);
         id_rd_addr = 5'(k + 20);
         @(posedge clk); #1;
         check($sformatf("hold%0d ex_valid", k), ex_valid, 1);
         check($sformatf("hold%0d salida1", k), salida1, 32'h12345678);
         check($sformatf("hold%0d ex_control", k), ex_control, 3);
         check($sformatf("hold%0d ex_dest", k), ex_dest, 12);
         check($sformatf("hold%0d store", k), ex_store_data, 32'hABCD);
      end
      stall = 1'b0;
      @(posedge clk); #1;
      check("post-hold capture control", ex_control, 10);
      check("post-hold capture salida1", salida1, 32'hF2);

      // Reset asserted mid-stall takes effect immediately
      stall = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_reset("mid reset");
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      hv = '{1, 1, 2, 3, 5, 7, 0, 2, 0, 1, 0, 0,  0, 0, 0,  1, 5, 7, 7, 2, 3, 1, 0, 0};
      apply_vec(hv, "after reset");
      check("scoreboard drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the ALU. It registers the decoded operands and control, then drives the ALU's salida1/salida3/control inputs.
- Resolves data hazards with EX/MEM and MEM/WB forwarding, plus decode-time write-through from MEM/WB.
- Detects load-use hazards: raises a stall request upstream and inserts a bubble into EX.
- Honours external stall (hold) and flush (branch squash) from the pipeline controller.

Parameters:
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU control code width
- REG_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_W each  source/destination register numbers
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_control  in  CTRL_W  ALU control code
- id_alusrc  in  1  1 = operand B is the immediate
- id_regwrite, id_memread, id_memwrite  in  1 each  instruction class flags
- stall  in  1  downstream hold; freezes this stage
- flush  in  1  squash; the next edge loads a bubble
- exmem_regwrite  in  1, exmem_rd  in  REG_W, exmem_result  in  DATA_W  EX/MEM forward source
- memwb_regwrite  in  1, memwb_rd  in  REG_W, memwb_result  in  DATA_W  MEM/WB forward/writeback source
- ex_valid  out  1  EX slot holds a real instruction
- salida1  out  DATA_W  ALU operand A (forwarded rs)
- salida3  out  DATA_W  ALU operand B (immediate or forwarded rt)
- ex_control  out  CTRL_W  ALU control code
- ex_store_data  out  DATA_W  forwarded rt, used as store data
- ex_dest  out  REG_W, ex_regwrite/ex_memread/ex_memwrite  out  1 each  registered flags
- load_use_stall  out  1  request upstream hold of IF/ID

Behaviour:
- Reset (rst_n low, asynchronous): all registered state goes to 0, so ex_valid=0, all flags=0, ex_dest=0 and ex_control=0. salida1/salida3/ex_store_data then evaluate to 0, unless forwarding matches are live, which cannot happen because ex_rs/ex_rt are 0.
- load_use_stall (combinational) is 1 when all of the following hold:
  - ex_valid & ex_memread & ex_dest!=0 & id_valid, and
  - ex_dest==id_rs_addr, or (ex_dest==id_rt_addr and (!id_alusrc or id_memwrite)).
- Per rising edge, in strict priority order:
  1. flush: load a bubble. ex_valid, ex_regwrite, ex_memread and ex_memwrite go to 0; ex_control goes to 0; data registers are don't-care.
  2. stall: hold every register unchanged.
  3. load_use_stall: load a bubble, as for flush.
  4. Otherwise capture all id_* inputs. Captured regwrite/memread/memwrite are gated by id_valid. Captured regwrite is forced 0 when id_rd_addr==0.
- Decode write-through at capture: if memwb_regwrite & memwb_rd!=0 & memwb_rd==id_rs_addr, the captured rs data is memwb_result instead of id_rs_data. rt is handled identically.
- Forwarding (combinational from registered ex_rs/ex_rt, applied independently to rs and rt):
  - EX/MEM match has priority: exmem_regwrite & exmem_rd!=0 & exmem_rd==reg → exmem_result.
  - Else MEM/WB match: memwb_regwrite & memwb_rd!=0 & memwb_rd==reg → memwb_result.
  - Else the registered data.
  - Register 0 is never forwarded.
- salida1 = forwarded rs. salida3 = ex_alusrc ? ex_imm : forwarded rt. ex_store_data is always forwarded rt.
- Latency: one cycle from id_* to the ex_* outputs. Forwarding adds zero cycles.
- Simultaneous flush and load_use_stall: flush wins and produces a bubble. The upstream controller still sees load_use_stall, which is harmless.
- Stall while ex_valid=0: a held bubble stays a bubble.
- Reset mid-stall: the reset value wins immediately.
- While ex_valid=0 the outputs still evaluate; downstream must qualify them with ex_valid.

Test Plan:
- Reset mid-operation → all ex_* outputs = 0 and load_use_stall = 0 immediately. After release, capture id_rs_data=5, id_rt_data=7, control=4'b0010 → next cycle salida1=5, salida3=7, ex_control=4'b0010, ex_valid=1.
- EX/MEM forward: EX holds rs=3, and exmem_rd=3, exmem_result=32'hAA, exmem_regwrite=1 → salida1=32'hAA. Also drive memwb_rd=3 with memwb_result=32'hBB simultaneously → still 32'hAA.
- Register-0 guard: exmem_rd=0, exmem_regwrite=1, EX rs=0 → salida1 = registered value, not forwarded. id_rd_addr=0 with id_regwrite=1 → ex_regwrite=0.
- Load-use: EX holds a load with ex_dest=8; ID has id_rs_addr=8 → load_use_stall=1 and the next cycle has ex_valid=0. Repeat with id_alusrc=1, id_memwrite=0 and only rt=8 → load_use_stall=0.
- Priority: assert flush and stall together → bubble. Assert stall alone for 3 cycles → ex_* held constant and id changes are ignored.
- Write-through: memwb_rd=4, memwb_result=32'h1234 in the same cycle that ID reads rs=4 with stale id_rs_data=0 → next cycle salida1=32'h1234, with no later forward active.
